// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree walker: interface widths, node-word
// layout (MSB first: is_leaf, feat_idx, threshold, left_child, right_child),
// the walker FSM state enum and the root node address.
package dt_pkg;

  localparam int unsigned NUM_FEATURES  = 16;
  localparam int unsigned FEAT_IDX_W    = 4;
  localparam int unsigned NODE_ADDR_W   = 8;
  localparam int unsigned CLASS_W       = 4;
  localparam int unsigned DEF_MAX_DEPTH = 16;
  localparam int unsigned FEAT_W        = 32;
  localparam int unsigned THR_W         = 27;

  // Node word field offsets (LSB positions) and total width.
  localparam int unsigned RIGHT_LSB = 0;
  localparam int unsigned LEFT_LSB  = RIGHT_LSB + NODE_ADDR_W;
  localparam int unsigned THR_LSB   = LEFT_LSB + NODE_ADDR_W;
  localparam int unsigned IDX_LSB   = THR_LSB + THR_W;
  localparam int unsigned LEAF_BIT  = IDX_LSB + FEAT_IDX_W;
  localparam int unsigned NODE_W    = 1 + FEAT_IDX_W + THR_W + 2 * NODE_ADDR_W;

  localparam logic [NODE_ADDR_W-1:0] ROOT_ADDR = '0;

  typedef struct packed {
    logic                   is_leaf;
    logic [FEAT_IDX_W-1:0]  feat_idx;
    logic [THR_W-1:0]       threshold;
    logic [NODE_ADDR_W-1:0] left_child;
    logic [NODE_ADDR_W-1:0] right_child;
  } dt_node_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_CMP_WAIT,
    ST_DONE
  } dt_state_e;

endpackage

// File: rtl/dt_feature_regfile.sv
// Feature register file for the tree walker.
// Ports: clk, rst_n (async active-low); we/waddr/wdata write port;
// raddr/rdata combinational read port. Indices outside NUM_FEATURES are
// dropped on write and read back as zero.
module dt_feature_regfile
  import dt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [FEAT_IDX_W-1:0] waddr,
  input  logic [FEAT_W-1:0]     wdata,
  input  logic [FEAT_IDX_W-1:0] raddr,
  output logic [FEAT_W-1:0]     rdata
);

  logic [FEAT_W-1:0] regs_q [NUM_FEATURES];
  logic [FEAT_W-1:0] regs_d [NUM_FEATURES];

  // Write decode: only an exact index match updates a register.
  always_comb begin
    for (int i = 0; i < int'(NUM_FEATURES); i++) begin
      regs_d[i] = regs_q[i];
      if (we && (waddr == FEAT_IDX_W'(i))) regs_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_FEATURES); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_FEATURES); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read mux; an unmatched index falls through to zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(NUM_FEATURES); i++) begin
      if (raddr == FEAT_IDX_W'(i)) rdata = regs_q[i];
    end
  end

endmodule

// File: rtl/dt_tree_walker.sv
// Decision-tree traversal controller (initiator of the threshold-compare
// interface). Walks from the root node, issuing feature/threshold pairs to
// the comparator and following its go-left decision until a leaf is found.
// Ports: clk, rst_n (async active-low); feat_we/feat_addr/feat_data feature
// writes (dropped while busy); start/busy walk control; node_rd_en/node_addr/
// node_data synchronous node memory; cmp_* comparator request/response;
// result_valid/result_class/result_error walk result.
// Optional macro DT_WALK_DEPTH_GUARD_EN adds a MAX_DEPTH internal-node limit
// that ends a walk with result_error=1 (protection against cyclic trees).
// cmp_valid/cmp_feature/cmp_threshold are driven in the DECODE cycle itself,
// straight from the arriving node word, so that an internal node costs three
// cycles with a one-cycle registered comparator.
module dt_tree_walker
  import dt_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   feat_we,
  input  logic [FEAT_IDX_W-1:0]  feat_addr,
  input  logic [FEAT_W-1:0]      feat_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   node_rd_en,
  output logic [NODE_ADDR_W-1:0] node_addr,
  input  logic [NODE_W-1:0]      node_data,
  output logic                   cmp_valid,
  output logic [FEAT_W-1:0]      cmp_feature,
  output logic [THR_W-1:0]       cmp_threshold,
  input  logic                   cmp_go_left,
  input  logic                   cmp_result_valid,
  output logic                   result_valid,
  output logic [CLASS_W-1:0]     result_class,
  output logic                   result_error
);

  dt_state_e              state_q, state_d;
  logic [NODE_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [NODE_ADDR_W-1:0] left_q, left_d;
  logic [NODE_ADDR_W-1:0] right_q, right_d;
  logic [CLASS_W-1:0]     class_q, class_d;
  logic [FEAT_W-1:0]      feat_hold_q, feat_hold_d;
  logic [THR_W-1:0]       thr_hold_q, thr_hold_d;
  dt_node_t               node;
  logic [FEAT_W-1:0]      feat_sel;
  logic                   cmp_issue_c;
  logic                   guard_hit_c;

  assign node = dt_node_t'(node_data);

  dt_feature_regfile u_feat_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (feat_we && (state_q == ST_IDLE)),
    .waddr (feat_addr),
    .wdata (feat_data),
    .raddr (node.feat_idx),
    .rdata (feat_sel)
  );

`ifdef DT_WALK_DEPTH_GUARD_EN
  localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               error_q, error_d;

  assign guard_hit_c = (depth_q == DEPTH_W'(MAX_DEPTH));

  // Depth counts compares taken this walk; error is decided when DONE is entered.
  always_comb begin
    depth_d = depth_q;
    error_d = error_q;
    if ((state_q == ST_IDLE) && start) depth_d = '0;
    if ((state_q == ST_CMP_WAIT) && cmp_result_valid) depth_d = depth_q + DEPTH_W'(1);
    if ((state_q == ST_DECODE) && (node.is_leaf || guard_hit_c)) error_d = !node.is_leaf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      error_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      error_q <= error_d;
    end
  end

  assign result_error = error_q;
`else
  assign guard_hit_c  = 1'b0;
  assign result_error = 1'b0;
`endif

  // Walker FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    left_d      = left_q;
    right_d     = right_q;
    class_d     = class_q;
    feat_hold_d = feat_hold_q;
    thr_hold_d  = thr_hold_q;
    cmp_issue_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d = ROOT_ADDR;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (node.is_leaf) begin
          class_d = node.threshold[CLASS_W-1:0];
          state_d = ST_DONE;
        end else if (guard_hit_c) begin
          class_d = '0;
          state_d = ST_DONE;
        end else begin
          cmp_issue_c = 1'b1;
          feat_hold_d = feat_sel;
          thr_hold_d  = node.threshold;
          left_d      = node.left_child;
          right_d     = node.right_child;
          state_d     = ST_CMP_WAIT;
        end
      end
      ST_CMP_WAIT: begin
        if (cmp_result_valid) begin
          cur_addr_d = cmp_go_left ? left_q : right_q;
          state_d    = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      left_q      <= '0;
      right_q     <= '0;
      class_q     <= '0;
      feat_hold_q <= '0;
      thr_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      left_q      <= left_d;
      right_q     <= right_d;
      class_q     <= class_d;
      feat_hold_q <= feat_hold_d;
      thr_hold_q  <= thr_hold_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign node_rd_en    = (state_q == ST_FETCH);
  assign node_addr     = cur_addr_q;
  assign result_valid  = (state_q == ST_DONE);
  assign result_class  = class_q;
  assign cmp_valid     = cmp_issue_c;
  assign cmp_feature   = cmp_issue_c ? feat_sel : feat_hold_q;
  assign cmp_threshold = cmp_issue_c ? node.threshold : thr_hold_q;

endmodule

// File: tb/tb_dt_tree_walker.sv
// Self-checking bench for dt_tree_walker: node memory and 1-cycle comparator
// models, a tree-walk reference model feeding result/address scoreboards, and
// a negedge monitor that pops and compares whenever the DUT presents output.
module tb_dt_tree_walker;
  import dt_pkg::*;

  localparam int unsigned CH_W = 2 * NODE_ADDR_W;
`ifdef DT_WALK_DEPTH_GUARD_EN
  localparam int MODEL_MAX_DEPTH = 2;
  localparam int unsigned TB_MAX_DEPTH = 2;
`else
  localparam int unsigned TB_MAX_DEPTH = DEF_MAX_DEPTH;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   feat_we;
  logic [FEAT_IDX_W-1:0]  feat_addr;
  logic [FEAT_W-1:0]      feat_data;
  logic                   start;
  logic                   busy;
  logic                   node_rd_en;
  logic [NODE_ADDR_W-1:0] node_addr;
  logic [NODE_W-1:0]      node_data;
  logic                   cmp_valid;
  logic [FEAT_W-1:0]      cmp_feature;
  logic [THR_W-1:0]       cmp_threshold;
  logic                   cmp_go_left;
  logic                   cmp_result_valid;
  logic                   result_valid;
  logic [CLASS_W-1:0]     result_class;
  logic                   result_error;

  always #5 clk = ~clk;

  dt_tree_walker #(.MAX_DEPTH(TB_MAX_DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .feat_we          (feat_we),
    .feat_addr        (feat_addr),
    .feat_data        (feat_data),
    .start            (start),
    .busy             (busy),
    .node_rd_en       (node_rd_en),
    .node_addr        (node_addr),
    .node_data        (node_data),
    .cmp_valid        (cmp_valid),
    .cmp_feature      (cmp_feature),
    .cmp_threshold    (cmp_threshold),
    .cmp_go_left      (cmp_go_left),
    .cmp_result_valid (cmp_result_valid),
    .result_valid     (result_valid),
    .result_class     (result_class),
    .result_error     (result_error)
  );

  typedef struct {
    int cls;
    int err;
    int lat;
    int t0;
  } exp_t;

  exp_t            exp_q[$];
  int              exp_addr_q[$];
  exp_t            mon_e;
  logic [NODE_W-1:0] mem [256];
  logic [31:0]     mfeat [NUM_FEATURES];
  int              cyc = 0;
  int              errors = 0;
  int              checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous node memory and registered comparator (go left when feature <= threshold).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_data        <= '0;
      cmp_result_valid <= 1'b0;
      cmp_go_left      <= 1'b0;
    end else begin
      if (node_rd_en) node_data <= mem[node_addr];
      cmp_result_valid <= cmp_valid;
      if (cmp_valid) cmp_go_left <= (cmp_feature <= 32'(cmp_threshold));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every fetch address and every result against the scoreboards.
  always @(negedge clk) begin
    if (rst_n) begin
      if (node_rd_en) begin
        if (exp_addr_q.size() == 0) check("unexpected_fetch", 64'(node_rd_en), 64'(0));
        else check("node_addr", 64'(node_addr), 64'(exp_addr_q.pop_front()));
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(result_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("result_class", 64'(result_class), 64'(mon_e.cls));
          check("result_error", 64'(result_error), 64'(mon_e.err));
          check("latency", 64'(cyc - mon_e.t0 + 1), 64'(mon_e.lat));
        end
      end
    end
  end

  // Reference model: plain walk over the memory array from the root.
  function automatic void push_model(input int t0);
    exp_t e;
    int a;
    int d;
    logic [NODE_W-1:0] w;
    logic [31:0] f;
    logic [31:0] thr;
    a = 0; d = 0; e.cls = 0; e.err = 0; e.t0 = t0;
    for (int step = 0; step < 1000; step++) begin
      w = mem[a];
      exp_addr_q.push_back(a);
      if (w[LEAF_BIT]) begin
        e.cls = int'(w[THR_LSB +: CLASS_W]);
        break;
      end
`ifdef DT_WALK_DEPTH_GUARD_EN
      if (d == MODEL_MAX_DEPTH) begin
        e.err = 1;
        e.cls = 0;
        break;
      end
`endif
      f   = mfeat[w[IDX_LSB +: FEAT_IDX_W]];
      thr = 32'(w[THR_LSB +: THR_W]);
      a   = (f <= thr) ? int'(w[LEFT_LSB +: NODE_ADDR_W]) : int'(w[RIGHT_LSB +: NODE_ADDR_W]);
      d++;
    end
    e.lat = 3 * d + 3;
    exp_q.push_back(e);
  endfunction

  function automatic logic [NODE_W-1:0] mk(input bit lf, input int idx, input int thr,
                                           input int l, input int r);
    return {lf, FEAT_IDX_W'(idx), THR_W'(thr), NODE_ADDR_W'(l), NODE_ADDR_W'(r)};
  endfunction

  task automatic wr_feat(input int idx, input logic [31:0] v, input bit to_model);
    @(negedge clk);
    feat_we = 1'b1; feat_addr = FEAT_IDX_W'(idx); feat_data = v;
    if (to_model) mfeat[idx] = v;
    @(negedge clk);
    feat_we = 1'b0;
  endtask

  task automatic pulse_start(input bit expect_walk);
    @(negedge clk);
    if (expect_walk) push_model(cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_walks(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending_results"}, 64'(exp_q.size()), 64'(0));
    check({name, "_pending_fetches"}, 64'(exp_addr_q.size()), 64'(0));
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic load_fixed_tree();
    for (int a = 0; a < 256; a++) mem[a] = mk(1'b1, 0, 0, 0, 0);
    mem[0] = mk(1'b0, 3, 100, 1, 2);
    mem[1] = mk(1'b0, 1, 7, 3, 4);
    mem[2] = mk(1'b1, 0, 2, 0, 0);
    mem[3] = mk(1'b1, 0, 6, 0, 0);
    mem[4] = mk(1'b1, 0, 9, 0, 0);
  endtask

  task automatic build_random_tree();
    logic [NODE_W-1:0] w;
    logic [THR_W-1:0]  thr;
    int l, r;
    for (int a = 0; a < 256; a++) begin
      if ((a >= 48) || ($urandom_range(0, 3) == 0)) begin
        w = {1'b1, FEAT_IDX_W'($urandom), THR_W'($urandom), CH_W'($urandom)};
      end else begin
        l   = a + 1 + int'($urandom_range(0, 9));
        r   = a + 1 + int'($urandom_range(0, 9));
        thr = ($urandom_range(0, 1) == 1) ? THR_W'($urandom_range(0, 300)) : THR_W'($urandom);
        w   = {1'b0, FEAT_IDX_W'($urandom_range(0, 15)), thr, NODE_ADDR_W'(l), NODE_ADDR_W'(r)};
      end
      mem[a] = w;
    end
  endtask

  task automatic random_feats();
    logic [31:0] v;
    for (int i = 0; i < int'(NUM_FEATURES); i++) begin
      case ($urandom_range(0, 3))
        0:       v = 32'($urandom_range(0, 300));
        1:       v = $urandom;
        2:       v = 32'h0800_0000 | 32'($urandom_range(0, 300));
        default: v = 32'h07FF_FFFF;
      endcase
      wr_feat(i, v, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; feat_we = 1'b0; feat_addr = '0; feat_data = '0;
    for (int i = 0; i < int'(NUM_FEATURES); i++) mfeat[i] = '0;
    load_fixed_tree();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_node_rd_en", 64'(node_rd_en), 64'(0));
    check("rst_node_addr", 64'(node_addr), 64'(0));
    check("rst_cmp_valid", 64'(cmp_valid), 64'(0));
    check("rst_cmp_feature", 64'(cmp_feature), 64'(0));
    check("rst_cmp_threshold", 64'(cmp_threshold), 64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_result_class", 64'(result_class), 64'(0));
    check("rst_result_error", 64'(result_error), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Root leaf, class 5.
    mem[0] = mk(1'b1, 0, 5, 0, 0);
    pulse_start(1'b1);
    wait_walks("root_leaf");
    check("root_leaf_class_held", 64'(result_class), 64'(5));

    // Depth 2: left at node0 (100<=100), right at node1 (8>7) -> class 9.
    load_fixed_tree();
    wr_feat(3, 32'd100, 1'b1);
    wr_feat(1, 32'd8, 1'b1);
    pulse_start(1'b1);
    wait_walks("depth2");
    check("depth2_class_held", 64'(result_class), 64'(9));
    check("depth2_idle", 64'(busy), 64'(0));

    // Feature write while busy is dropped; the next walk sees the old value.
    pulse_start(1'b1);
    check("busy_mid_walk", 64'(busy), 64'(1));
    wr_feat(3, 32'd200, 1'b0);
    wait_walks("wr_busy_walk1");
    pulse_start(1'b1);
    wait_walks("wr_busy_walk2");
    check("wr_busy_class_held", 64'(result_class), 64'(9));

    // start while busy is ignored: exactly one result.
    pulse_start(1'b1);
    repeat (2) @(negedge clk);
    pulse_start(1'b0);
    wait_walks("start_busy");
    repeat (12) @(negedge clk);

    // Reset during CMP_WAIT.
    begin
      int n;
      pulse_start(1'b1);
      n = 0;
      while (!cmp_valid && (n < 50)) begin
        @(negedge clk);
        n++;
      end
      check("reach_cmp", 64'(cmp_valid), 64'(1));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_node_rd_en", 64'(node_rd_en), 64'(0));
      check("midrst_node_addr", 64'(node_addr), 64'(0));
      check("midrst_cmp_valid", 64'(cmp_valid), 64'(0));
      check("midrst_result_valid", 64'(result_valid), 64'(0));
      check("midrst_result_class", 64'(result_class), 64'(0));
      exp_q.delete();
      exp_addr_q.delete();
      for (int i = 0; i < int'(NUM_FEATURES); i++) mfeat[i] = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      // feat[1] is 0 after reset, so node1 now goes left to class 6.
      wr_feat(3, 32'd100, 1'b1);
      pulse_start(1'b1);
      wait_walks("after_reset");
      check("after_reset_class_held", 64'(result_class), 64'(6));
    end

`ifdef DT_WALK_DEPTH_GUARD_EN
    // Cyclic memory: node0 <-> node1 trips the depth guard.
    mem[0] = mk(1'b0, 0, 0, 1, 1);
    mem[1] = mk(1'b0, 0, 0, 0, 0);
    pulse_start(1'b1);
    wait_walks("guard");
    check("guard_error_held", 64'(result_error), 64'(1));
    check("guard_class_held", 64'(result_class), 64'(0));
`endif

    // Randomized trees and feature vectors.
    for (int t = 0; t < 4; t++) begin
      build_random_tree();
      random_feats();
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 2) == 0)
          wr_feat(int'($urandom_range(0, 15)), 32'($urandom_range(0, 300)), 1'b1);
        pulse_start(1'b1);
        wait_walks("random");
      end
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dt_tree_walker.md
# dt_tree_walker

Traversal controller for the decision-tree IP core; it is the initiator side of the threshold-compare interface. It holds the current feature vector (CAN-derived features written by the feature extractor), fetches node words from the synchronous node memory, and issues feature/threshold pairs to the threshold comparator. It follows the comparator's go-left decision from the root to a leaf and reports the leaf class to the classification output stage.

## Interface
- NUM_FEATURES, 16: feature register count.
- FEAT_IDX_W, 4: feature index width.
- NODE_ADDR_W, 8: node memory address width; root is address 0.
- CLASS_W, 4: class label width.
- MAX_DEPTH, 16: internal-node limit per walk (guard only, see Configuration).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- feat_we  in  1  feature write strobe.
- feat_addr  in  FEAT_IDX_W  feature register index.
- feat_data  in  32  unsigned feature value.
- start  in  1  begin a walk; single-cycle pulse.
- busy  out  1  high from the cycle after start is accepted until result_valid.
- node_rd_en  out  1  node memory read enable.
- node_addr  out  NODE_ADDR_W  node memory address.
- node_data  in  1+FEAT_IDX_W+27+2*NODE_ADDR_W  node word, valid the cycle after node_rd_en.
- cmp_valid  out  1  compare request, one-cycle pulse.
- cmp_feature  out  32  selected feature value.
- cmp_threshold  out  27  node threshold.
- cmp_go_left  in  1  comparator decision.
- cmp_result_valid  in  1  comparator decision valid.
- result_valid  out  1  one-cycle pulse, walk complete.
- result_class  out  CLASS_W  leaf class, held until the next walk completes.
- result_error  out  1  depth limit hit; qualified by result_valid.

## Operation
- Node word, MSB first: is_leaf, feat_idx, threshold[26:0], left_child, right_child. On a leaf, the class is threshold[CLASS_W-1:0].
- Feature registers: written on feat_we only while busy=0; writes while busy are dropped. feat_addr ≥ NUM_FEATURES is dropped on write and reads as 0 on select.
- FSM states: IDLE, FETCH, DECODE, CMP_WAIT, DONE.
- IDLE: start=1 → cur_addr=0, depth=0, go to FETCH. start while busy is ignored.
- FETCH: node_rd_en=1, node_addr=cur_addr, then go to DECODE.
- DECODE: sample node_data.
  - Leaf: latch class, result_error=0, go to DONE.
  - Internal node: drive cmp_valid=1 with cmp_feature=feat[feat_idx] and cmp_threshold=threshold, latch both children, go to CMP_WAIT.
- CMP_WAIT: hold until cmp_result_valid=1. Then cur_addr = cmp_go_left ? left_child : right_child, depth+1, go to FETCH. cmp_result_valid outside CMP_WAIT is ignored.
- DONE: result_valid=1 for one cycle, go to IDLE.
- Comparator semantics: go_left when feature ≤ zero-extended threshold, unsigned.

## Timing
- Reset values: all outputs 0, FSM in IDLE, feature registers 0, cur_addr and depth 0.
- Reset mid-walk: immediate return to IDLE with no result_valid. A walk in flight is lost.
- Comparator latency 1 cycle (registered) gives 3 cycles per internal node.
- Latency: result_valid is high 3·D+3 cycles after the edge sampling start, where D is the number of internal nodes visited.
- busy=1 from FETCH through DONE inclusive.
- A new start is accepted in IDLE, including the cycle after DONE.
- cmp_feature and cmp_threshold are valid only while cmp_valid=1. Their value is don't-care otherwise and is held in the implementation.

## Configuration
- DT_WALK_DEPTH_GUARD_EN defined:
  - In DECODE, an internal node seen with depth == MAX_DEPTH goes to DONE with result_error=1 and result_class=0, and no compare is issued.
  - This protects against cyclic node memory.
- Undefined: no depth counter. result_error is tied to 0, and the walk runs until a leaf is reached.

## Structure
- Shared dt_pkg holds:
  - node-word field offsets and widths;
  - the NODE_W localparam;
  - the FSM state enum;
  - the ROOT_ADDR constant (0).
- One sub-module, dt_feature_regfile: write port plus combinational read mux with the out-of-range→0 rule.

## Test plan
- Root leaf, class 5: start → result_valid 3 cycles later, result_class=5, result_error=0.
- Depth 2:
  - Node0 compares feat[3] with threshold 100; node1 compares feat[1] with threshold 7; node4 is a leaf with class 9. Comparator model has 1-cycle latency.
  - Stimulus: feat[3]=100, feat[1]=8.
  - Expect: left at node0 (100≤100), then right at node1. result_class=9, latency 9 cycles, node_addr sequence 0,1,4.
- Feature write while busy: feat_we to feat[3] mid-walk → dropped. The next walk uses the old value.
- start while busy: pulse mid-walk → ignored, exactly one result_valid.
- rst_n low during CMP_WAIT:
  - Outputs return to 0 asynchronously and no result_valid is produced.
  - Feature registers read 0 afterwards.
  - After release, a new start with feat[3]=100 rewritten completes normally.
- Guard (macro defined, MAX_DEPTH=2): node memory where node0 and node1 are internal and each points back to the other → result_valid with result_error=1 after 9 cycles.
